// File: rtl/mnist_infer_ctrl_if.sv
// Pixel stream and engine connection for the MNIST frame sequencer.
// The sequencer uses the slave view; the pixel source and engine use the master view.
interface mnist_infer_ctrl_if #(
  parameter int IMG_BITS = 784
);
  logic                pix_valid;
  logic                pix_data;
  logic                pix_last;
  logic                pix_ready;
  logic                eng_start;
  logic [IMG_BITS-1:0] eng_img;
  logic                eng_done;
  logic [6:0]          eng_hex;

  modport slave (
    input  pix_valid, pix_data, pix_last, eng_done, eng_hex,
    output pix_ready, eng_start, eng_img
  );

  modport master (
    output pix_valid, pix_data, pix_last, eng_done, eng_hex,
    input  pix_ready, eng_start, eng_img
  );
endinterface

// File: rtl/mnist_infer_ctrl.sv
// Frame-level sequencer for the MNIST inference engine: gathers a 1-bit pixel
// stream into a frame buffer, starts the engine, waits for done under a
// watchdog and reports the 7-seg result, error pulses and a frame count.
module mnist_infer_ctrl #(
  parameter int IMG_BITS    = 784,
  parameter int TIMEOUT_CYC = 16384,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  mnist_infer_ctrl_if.slave bus,
  output logic              res_valid,
  output logic [6:0]        res_hex,
  output logic              err_frame,
  output logic              err_tmo,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int IDX_W = $clog2(IMG_BITS);
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IMG_BITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [IMG_BITS-1:0] img_q;
  logic                img_we;
  logic                res_valid_q, res_valid_d;
  logic                err_frame_q, err_frame_d;
  logic                err_tmo_q, err_tmo_d;
  logic [6:0]          res_hex_q, res_hex_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                beat;

  // A beat transfers only while the sequencer is loading.
  assign beat = bus.pix_valid && (state_q == S_LOAD);

  // Next-state, index, watchdog and result decisions; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    timer_d     = timer_q;
    img_we      = 1'b0;
    res_valid_d = 1'b0;
    err_frame_d = 1'b0;
    err_tmo_d   = 1'b0;
    res_hex_d   = res_hex_q;
    cnt_d       = cnt_q;
    if (abort) begin
      state_d  = S_LOAD;
      wr_idx_d = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (beat) begin
            img_we = 1'b1;
            if (wr_idx_q == IDX_LAST) begin
              wr_idx_d = '0;
              if (bus.pix_last) state_d = S_START;
              else              err_frame_d = 1'b1;   // frame overran without a last marker
            end else if (bus.pix_last) begin
              wr_idx_d    = '0;                       // short frame
              err_frame_d = 1'b1;
            end else begin
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
        S_START: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so it wins over a simultaneous watchdog expiry
          if (bus.eng_done) begin
            res_hex_d   = bus.eng_hex;
            res_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            state_d     = S_LOAD;
          end else if (timer_q == TMR_LAST) begin
            err_tmo_d = 1'b1;
            state_d   = S_LOAD;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Control state, counters and one-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      wr_idx_q    <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      res_hex_q   <= 7'b1111111;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      err_frame_q <= err_frame_d;
      err_tmo_q   <= err_tmo_d;
      res_hex_q   <= res_hex_d;
      cnt_q       <= cnt_d;
    end
  end

  // Frame buffer: written only by accepted beats, so it holds still outside S_LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      img_q <= '0;
    else if (img_we) img_q[wr_idx_q] <= bus.pix_data;
  end

  assign bus.pix_ready = (state_q == S_LOAD);
  // Start is the registered S_START state; an abort in that same cycle cancels it.
  assign bus.eng_start = (state_q == S_START) && !abort;
  assign bus.eng_img   = img_q;
  assign res_valid     = res_valid_q;
  assign res_hex       = res_hex_q;
  assign err_frame     = err_frame_q;
  assign err_tmo       = err_tmo_q;
  assign frame_cnt     = cnt_q;
  assign busy          = (state_q != S_LOAD) || (wr_idx_q != '0);
endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Self-checking bench for mnist_infer_ctrl: randomized frames and engine
// timing compared against a frame-level reference model.
module tb_mnist_infer_ctrl;
  localparam int IMG = 784;
  localparam int TMO = 64;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          abort;
  logic          res_valid;
  logic [6:0]    res_hex;
  logic          err_frame;
  logic          err_tmo;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  mnist_infer_ctrl_if #(.IMG_BITS(IMG)) bus ();

  mnist_infer_ctrl #(.IMG_BITS(IMG), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .bus       (bus),
    .res_valid (res_valid),
    .res_hex   (res_hex),
    .err_frame (err_frame),
    .err_tmo   (err_tmo),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: count each pulse and remember the cycle it was seen in.
  int n_start = 0, n_res = 0, n_ef = 0, n_tmo = 0;
  int t_start = -1, t_res = -1, t_ef = -1, t_tmo = -1;
  always @(negedge clk) begin
    if (bus.eng_start) begin n_start++; t_start = cyc; end
    if (res_valid)     begin n_res++;   t_res   = cyc; end
    if (err_frame)     begin n_ef++;    t_ef    = cyc; end
    if (err_tmo)       begin n_tmo++;   t_tmo   = cyc; end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [IMG-1:0] got, input logic [IMG-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state (frame level)
  logic [IMG-1:0] mdl_img;
  int             mdl_idx;
  logic [6:0]     mdl_hex;
  logic [CW-1:0]  mdl_cnt;

  task automatic mdl_reset();
    mdl_img = '0;
    mdl_idx = 0;
    mdl_hex = 7'h7F;
    mdl_cnt = '0;
  endtask

  // Send n beats (pix_last on beat last_at, abort on beat abort_beat), then if a
  // complete frame was accepted run the engine: done d cycles after the start
  // cycle with code hex, abort wa cycles after start (wa<0: never).
  task automatic do_frame(input string name, input int n, input int last_at, input int abort_beat,
                          input int mode, input int d, input logic [6:0] hex, input int wa);
    int s_start, s_ef, s_res, s_tmo;
    int exp_ef, t_ef_exp, t_last, exp_res, exp_tmo, t_res_exp, t_tmo_exp, len, w;
    bit frame_ok;
    logic data;
    s_start = n_start; s_ef = n_ef; s_res = n_res; s_tmo = n_tmo;
    exp_ef = 0; t_ef_exp = -1; t_last = -1; frame_ok = 0;
    exp_res = 0; exp_tmo = 0; t_res_exp = -1; t_tmo_exp = -1;
    for (int k = 1; k <= n; k++) begin
      if ($urandom_range(3) == 0) begin
        bus.pix_valid = 1'b0;
        tick();
      end
      data = (mode == 0) ? logic'(k % 2) : logic'($urandom_range(1));
      bus.pix_valid = 1'b1;
      bus.pix_data  = data;
      bus.pix_last  = (k == last_at);
      abort         = (k == abort_beat);
      w = 0;
      while (!bus.pix_ready && w < 50) begin tick(); w++; end
      if (w == 50) chk({name, "_ready_timeout"}, bus.pix_ready, 1'b1);
      if (k == 1) chk({name, "_ready_first"}, bus.pix_ready, 1'b1);
      tick();
      if (abort) begin
        mdl_idx = 0;
      end else begin
        mdl_img[mdl_idx] = data;
        mdl_idx++;
        if (bus.pix_last && mdl_idx == IMG) begin
          frame_ok = 1; t_last = cyc; mdl_idx = 0;
        end else if (bus.pix_last || mdl_idx == IMG) begin
          exp_ef++; t_ef_exp = cyc; mdl_idx = 0;
        end
      end
      abort = 1'b0; bus.pix_valid = 1'b0; bus.pix_last = 1'b0;
    end

    if (frame_ok) begin
      if (wa == 0) abort = 1'b1;
      chk({name, "_img_at_start"}, bus.eng_img, mdl_img);
      chk({name, "_ready_in_start"}, bus.pix_ready, 1'b0);
      tick();
      abort = 1'b0;
      chk({name, "_start_count"}, n_start - s_start, (wa == 0) ? 0 : 1);
      if (wa != 0) begin
        chk({name, "_start_time"}, t_start, t_last);
        len = ((d > TMO) ? d : TMO + 1) + 2;
        for (int j = 1; j <= len; j++) begin
          bus.eng_done = (j == d);
          bus.eng_hex  = (j == d) ? hex : 7'($urandom);
          abort        = (j == wa);
          if (j == 1) chk({name, "_img_hold"}, bus.eng_img, mdl_img);
          tick();
        end
        bus.eng_done = 1'b0;
        abort = 1'b0;
        if (wa >= 1 && wa <= d && wa <= TMO) begin
          // aborted while waiting: no result, no timeout
        end else if (d <= TMO) begin
          exp_res = 1; t_res_exp = t_last + d + 1;
          mdl_hex = hex; mdl_cnt = mdl_cnt + 1'b1;
        end else begin
          // watchdog window is the TMO cycles after the start cycle; pulse follows it
          exp_tmo = 1; t_tmo_exp = t_last + TMO + 1;
        end
      end
    end
    tick();
    tick();
    chk({name, "_err_frame_count"}, n_ef - s_ef, exp_ef);
    if (exp_ef > 0) chk({name, "_err_frame_time"}, t_ef, t_ef_exp);
    if (!frame_ok) chk({name, "_no_start"}, n_start - s_start, 0);
    chk({name, "_res_count"}, n_res - s_res, exp_res);
    if (exp_res > 0) chk({name, "_res_time"}, t_res, t_res_exp);
    chk({name, "_tmo_count"}, n_tmo - s_tmo, exp_tmo);
    if (exp_tmo > 0) chk({name, "_tmo_time"}, t_tmo, t_tmo_exp);
    chk({name, "_res_hex"}, res_hex, mdl_hex);
    chk({name, "_frame_cnt"}, frame_cnt, mdl_cnt);
    chk({name, "_ready_after"}, bus.pix_ready, 1'b1);
    chk({name, "_busy_after"}, busy, mdl_idx != 0);
    $display("[TB] %s: beats=%0d start=%0d res=%0d tmo=%0d err_frame=%0d cnt=%0d",
             name, n, n_start - s_start, n_res - s_res, n_tmo - s_tmo, n_ef - s_ef, frame_cnt);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d, wa;
    logic [6:0] hx;
    mdl_reset();
    rst_n = 1'b0; abort = 1'b0;
    bus.pix_valid = 1'b1; bus.pix_data = 1'b1; bus.pix_last = 1'b0;
    bus.eng_done = 1'b0; bus.eng_hex = 7'h00;
    repeat (5) tick();
    chk("rst_pix_ready", bus.pix_ready, 1'b1);
    chk("rst_eng_start", bus.eng_start, 1'b0);
    chk("rst_res_hex", res_hex, 7'h7F);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_eng_img", bus.eng_img, 0);
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1'b0);

    do_frame("good_alt",     IMG, IMG, 0, 0, 40, 7'b1111001, -1);
    do_frame("short100",     100, 100, 0, 1, 0, 7'h00, -1);
    do_frame("good_after_short", IMG, IMG, 0, 1, 25, 7'b0100100, -1);
    do_frame("no_last",      IMG, 0, 0, 1, 0, 7'h00, -1);
    do_frame("good_after_nolast", IMG, IMG, 0, 1, 7, 7'b0110000, -1);
    do_frame("timeout_late_done", IMG, IMG, 0, 1, TMO + 5, 7'b0000000, -1);
    do_frame("abort_beat400", 400, 0, 400, 1, 0, 7'h00, -1);
    do_frame("good_after_abort", IMG, IMG, 0, 1, 12, 7'b0011001, -1);
    do_frame("abort_in_wait", IMG, IMG, 0, 1, 30, 7'b0010010, 20);
    do_frame("done_on_timeout", IMG, IMG, 0, 1, TMO, 7'b0000010, -1);
    do_frame("abort_in_start", IMG, IMG, 0, 1, 10, 7'b1111000, 0);
    do_frame("timeout_edge", IMG, IMG, 0, 1, TMO + 1, 7'b0000001, -1);

    for (int r = 0; r < 6; r++) begin
      d  = $urandom_range(1, TMO + 4);
      hx = 7'($urandom);
      wa = ($urandom_range(3) == 0) ? $urandom_range(1, TMO) : -1;
      do_frame($sformatf("rand%0d", r), IMG, IMG, 0, 1, d, hx, wa);
    end

    // reset in the middle of a frame returns everything to reset values
    do_frame("partial50", 50, 0, 0, 1, 0, 7'h00, -1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_res_hex", res_hex, 7'h7F);
    chk("midrst_eng_img", bus.eng_img, 0);
    tick();
    rst_n = 1'b1;
    mdl_reset();
    tick();
    do_frame("good_after_rst", IMG, IMG, 0, 1, 33, 7'b1000000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
